// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port 10x10 board RAM between the
// flipper (read/write), move validator (read) and display scanner (read).
// Round-robin grant with a flipper lock for read-modify-write sequences,
// one-cycle read return, and out-of-range address trapping.
module board_mem_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 2,
   parameter int CELLS  = 100
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flip_req,
   input  logic              vali_req,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] flip_addr,
   input  logic [ADDR_W-1:0] vali_addr,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic              flip_we,
   input  logic [DATA_W-1:0] flip_wdata,
   input  logic              flip_lock,
   output logic              flip_gnt,
   output logic              vali_gnt,
   output logic              disp_gnt,
   output logic              flip_rvalid,
   output logic              vali_rvalid,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] flip_rdata,
   output logic [DATA_W-1:0] vali_rdata,
   output logic [DATA_W-1:0] disp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              addr_err,
   output logic              busy
);

   // rr_ptr names the requester with highest priority this cycle
   typedef enum logic [1:0] {
      PTR_FLIP = 2'd0,
      PTR_VALI = 2'd1,
      PTR_DISP = 2'd2
   } ptr_t;

   ptr_t              rr_ptr, rr_ptr_nxt;
   logic              locked, locked_nxt;
   logic [2:0]        req;          // {disp, vali, flip}
   logic [2:0]        gnt;          // {disp, vali, flip}
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_oor;

   // Return stage: one cycle behind the grant
   logic [2:0]        rvalid_p1;
   logic              err_p1;
   logic [DATA_W-1:0] ret_data;
   logic [DATA_W-1:0] flip_hold, vali_hold, disp_hold;

   assign req = {disp_req, vali_req, flip_req};

   // Grant selection: lock overrides round-robin; nothing granted in reset
   always_comb begin
      gnt = 3'b000;
      if (!reset) begin
         if (locked && flip_req) begin
            gnt = 3'b001;
         end else begin
            case (rr_ptr)
               PTR_FLIP: begin
                  if (req[0])      gnt = 3'b001;
                  else if (req[1]) gnt = 3'b010;
                  else if (req[2]) gnt = 3'b100;
               end
               PTR_VALI: begin
                  if (req[1])      gnt = 3'b010;
                  else if (req[2]) gnt = 3'b100;
                  else if (req[0]) gnt = 3'b001;
               end
               PTR_DISP: begin
                  if (req[2])      gnt = 3'b100;
                  else if (req[0]) gnt = 3'b001;
                  else if (req[1]) gnt = 3'b010;
               end
               default: gnt = 3'b000;
            endcase
         end
      end
   end

   // Address of the granted requester and its range check
   always_comb begin
      sel_addr = '0;
      case (gnt)
         3'b001:  sel_addr = flip_addr;
         3'b010:  sel_addr = vali_addr;
         3'b100:  sel_addr = disp_addr;
         default: sel_addr = '0;
      endcase
      sel_oor = (gnt != 3'b000) &&
                ({1'b0, sel_addr} >= (ADDR_W + 1)'(CELLS));
   end

   assign flip_gnt  = gnt[0];
   assign vali_gnt  = gnt[1];
   assign disp_gnt  = gnt[2];

   // Out-of-range accesses are steered to cell 0 and never written
   assign mem_addr  = ((gnt != 3'b000) && !sel_oor) ? sel_addr : '0;
   assign mem_we    = gnt[0] & flip_we & ~sel_oor;
   assign mem_wdata = gnt[0] ? flip_wdata : '0;

   // Next pointer/lock: pointer moves past the granted requester
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      locked_nxt = gnt[0] & flip_lock;
      if (gnt[0])      rr_ptr_nxt = PTR_VALI;
      else if (gnt[1]) rr_ptr_nxt = PTR_DISP;
      else if (gnt[2]) rr_ptr_nxt = PTR_FLIP;
   end

   // Arbitration state register
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= PTR_FLIP;
         locked <= 1'b0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
         locked <= locked_nxt;
      end
   end

   // ---- grant stage / return stage boundary ----
   // Remember which read completes next cycle and whether it was out of range
   always_ff @(posedge clock) begin
      if (reset) begin
         rvalid_p1 <= 3'b000;
         err_p1    <= 1'b0;
      end else begin
         rvalid_p1 <= {gnt[2], gnt[1], gnt[0] & ~flip_we};
         err_p1    <= sel_oor;
      end
   end

   // Out-of-range reads return the border code instead of RAM data
   assign ret_data = err_p1 ? {DATA_W{1'b1}} : mem_rdata;

   // Per-requester read data holds its last returned value
   always_ff @(posedge clock) begin
      if (reset) begin
         flip_hold <= '0;
         vali_hold <= '0;
         disp_hold <= '0;
      end else begin
         if (rvalid_p1[0]) flip_hold <= ret_data;
         if (rvalid_p1[1]) vali_hold <= ret_data;
         if (rvalid_p1[2]) disp_hold <= ret_data;
      end
   end

   // Reset silences anything still pending from the previous cycle
   assign flip_rvalid = rvalid_p1[0] & ~reset;
   assign vali_rvalid = rvalid_p1[1] & ~reset;
   assign disp_rvalid = rvalid_p1[2] & ~reset;
   assign addr_err    = err_p1 & ~reset;

   assign flip_rdata  = reset ? '0 : (rvalid_p1[0] ? ret_data : flip_hold);
   assign vali_rdata  = reset ? '0 : (rvalid_p1[1] ? ret_data : vali_hold);
   assign disp_rdata  = reset ? '0 : (rvalid_p1[2] ? ret_data : disp_hold);

   assign busy = (gnt != 3'b000) | flip_rvalid | vali_rvalid | disp_rvalid;

endmodule
